// File: rtl/jump_ctrl.sv
// Per-frame vertical-motion sequencer: turns jump presses into char_y updates once per vsync rising edge.
// Optional feature: define DOUBLE_JUMP_EN to allow one extra jump while airborne.
module jump_ctrl #(
    parameter int Y_START  = 400,
    parameter int Y_MIN    = 0,
    parameter int JUMP_VEL = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        jump_btn,
    input  logic        on_ground,
    output logic [11:0] char_y,
    output logic [1:0]  state_o,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2
    } state_t;

    localparam logic signed [7:0]  V_JUMP = 8'(0 - JUMP_VEL);
    localparam logic signed [7:0]  V_GRAV = 8'(GRAVITY);
    localparam logic signed [7:0]  V_MAX  = 8'(MAX_FALL);
    localparam logic signed [13:0] Y_LO   = 14'(Y_MIN);
    localparam logic signed [13:0] Y_HI   = 14'sd4095;

    state_t             state, state_n;
    logic signed [7:0]  vel, vel_n;
    logic [11:0]        y_n;
    logic               vsync_q, btn_q, jump_pend;
    logic               btn_edge;
    logic signed [13:0] y_sum;
    logic [11:0]        y_clamp;
    logic signed [7:0]  vel_plus, fall_vel;

`ifdef DOUBLE_JUMP_EN
    logic air_used;
    logic air_take;
`endif

    assign frame_tick = vsync & ~vsync_q;
    assign btn_edge   = jump_btn & ~btn_q;

    // Edge detectors and the one-frame jump request latch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q   <= 1'b0;
            btn_q     <= 1'b0;
            jump_pend <= 1'b0;
        end else begin
            vsync_q <= vsync;
            btn_q   <= jump_btn;
            if (frame_tick)
                jump_pend <= 1'b0;
            else if (btn_edge)
                jump_pend <= 1'b1;
        end
    end

    // Candidate position after applying the current velocity, clamped to the screen.
    always_comb begin
        y_sum    = $signed({2'b00, char_y}) + $signed({{6{vel[7]}}, vel});
        vel_plus = vel + V_GRAV;
        fall_vel = (vel_plus > V_MAX) ? V_MAX : vel_plus;
        if (y_sum < Y_LO)
            y_clamp = 12'(Y_MIN);
        else if (y_sum > Y_HI)
            y_clamp = 12'hFFF;
        else
            y_clamp = y_sum[11:0];
    end

    // State register: motion state only moves on frame_tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FALL;
            vel    <= 8'sd0;
            char_y <= 12'(Y_START);
        end else if (frame_tick) begin
            state  <= state_n;
            vel    <= vel_n;
            char_y <= y_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        vel_n   = vel;
        y_n     = char_y;
`ifdef DOUBLE_JUMP_EN
        air_take = 1'b0;
`endif
        case (state)
            GROUND: begin
                vel_n = 8'sd0;
                if (jump_pend) begin
                    state_n = RISE;
                    vel_n   = V_JUMP;
                end else if (!on_ground) begin
                    state_n = FALL;
                end
            end
            RISE: begin
`ifdef DOUBLE_JUMP_EN
                if (jump_pend && !air_used) begin
                    vel_n    = V_JUMP;
                    air_take = 1'b1;
                end else begin
`else
                begin
`endif
                    if (y_sum <= Y_LO) begin
                        y_n     = 12'(Y_MIN);
                        vel_n   = 8'sd0;
                        state_n = FALL;
                    end else begin
                        y_n   = y_clamp;
                        vel_n = vel_plus;
                        if (!vel_plus[7])
                            state_n = FALL;
                    end
                end
            end
            FALL: begin
                if (on_ground) begin
                    state_n = GROUND;
                    vel_n   = 8'sd0;
`ifdef DOUBLE_JUMP_EN
                end else if (jump_pend && !air_used) begin
                    state_n  = RISE;
                    vel_n    = V_JUMP;
                    air_take = 1'b1;
`endif
                end else begin
                    y_n   = y_clamp;
                    vel_n = fall_vel;
                end
            end
            default: begin
                state_n = FALL;
                vel_n   = 8'sd0;
            end
        endcase
    end

`ifdef DOUBLE_JUMP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            air_used <= 1'b0;
        else if (frame_tick) begin
            if (state_n == GROUND && state != GROUND)
                air_used <= 1'b0;
            else if (air_take)
                air_used <= 1'b1;
        end
    end
`endif

    // Output logic.
    always_comb begin
        state_o = state;
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Bench for jump_ctrl: table of per-frame vectors plus hand-written corner sequences.
module tb_jump_ctrl;

    logic        clk = 1'b0;
    logic        rst, vsync, jump_btn, on_ground, og_low;
    logic [11:0] char_y, char_y_low;
    logic [1:0]  state_o, state_low;
    logic        frame_tick, tick_low;

    int errors = 0;
    int checks = 0;
    logic [13:0] exp_q[$];

    typedef struct {
        logic        og;
        logic        btn;
        logic [1:0]  st;
        logic [11:0] y;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    jump_ctrl dut (
        .clk(clk), .rst(rst), .vsync(vsync), .jump_btn(jump_btn),
        .on_ground(on_ground), .char_y(char_y), .state_o(state_o),
        .frame_tick(frame_tick)
    );

    jump_ctrl #(.Y_START(5)) dut_low (
        .clk(clk), .rst(rst), .vsync(vsync), .jump_btn(jump_btn),
        .on_ground(og_low), .char_y(char_y_low), .state_o(state_low),
        .frame_tick(tick_low)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press();
        @(negedge clk) jump_btn = 1'b1;
        @(negedge clk) jump_btn = 1'b0;
    endtask

    function automatic void add(input logic og, input logic btn, input logic [1:0] st, input logic [11:0] y);
        vec_t v;
        v.og = og; v.btn = btn; v.st = st; v.y = y;
        vecs.push_back(v);
    endfunction

    // One frame: optional press, vsync pulse, compare the post-tick state and hold over the frame.
    task automatic run_frame(input logic og, input logic btn, input logic [1:0] st,
                             input logic [11:0] y, input bit low, input string name);
        logic [13:0] exp;
        logic [13:0] act;
        on_ground = og;
        og_low    = og;
        if (btn) press();
        @(negedge clk);
        vsync = 1'b1;
        exp_q.push_back({st, y});
        #1 check({name, "_tick"}, low ? tick_low : frame_tick, 1);
        @(negedge clk);
        exp = exp_q.pop_front();
        act = low ? {state_low, char_y_low} : {state_o, char_y};
        check({name, "_st"}, act[13:12], exp[13:12]);
        check({name, "_y"}, act[11:0], exp[11:0]);
        @(negedge clk) vsync = 1'b0;
        repeat (3) @(negedge clk);
        act = low ? {state_low, char_y_low} : {state_o, char_y};
        check({name, "_hold"}, act, exp);
    endtask

    initial begin
        logic [11:0] y;
        rst = 1'b0; vsync = 1'b0; jump_btn = 1'b0; on_ground = 1'b0; og_low = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_y", char_y, 400);
        check("rst_st", state_o, 2);
        check("rst_tick", frame_tick, 0);
        check("rst_y_low", char_y_low, 5);
        rst = 1'b1;

        // Landing after a short fall, a full jump, walking off and terminal velocity.
        add(0, 0, 2, 400); add(0, 0, 2, 401); add(0, 0, 2, 403);
        add(1, 0, 0, 403); add(1, 0, 0, 403);
        add(1, 1, 1, 403);
        y = 403;
        for (int k = 12; k >= 1; k--) begin
            y = y - 12'(k);
            add(1, 0, (k == 1) ? 2'd2 : 2'd1, y);
        end
        add(1, 0, 0, 325);
        add(0, 0, 2, 325);
        for (int k = 0; k < 15; k++) begin
            y = y + 12'((k > 10) ? 10 : k);
            add(0, 0, 2, y);
        end
        add(1, 0, 0, 420);
        foreach (vecs[i])
            run_frame(vecs[i].og, vecs[i].btn, vecs[i].st, vecs[i].y, 0, $sformatf("vec%0d", i));

        // Held button: one jump, then no retrigger after landing.
        @(negedge clk) jump_btn = 1'b1;
        run_frame(1, 0, 1, 420, 0, "hold_jump");
        y = 420;
        for (int k = 12; k >= 1; k--) begin
            y = y - 12'(k);
            run_frame(1, 0, (k == 1) ? 2'd2 : 2'd1, y, 0, "hold_rise");
        end
        for (int k = 0; k < 3; k++)
            run_frame(1, 0, 0, 342, 0, "hold_ground");
        @(negedge clk) jump_btn = 1'b0;

        // Two edges within one frame give a single jump at normal speed.
        press();
        run_frame(1, 1, 1, 342, 0, "dbl_edge");
        y = 342;
        for (int k = 12; k >= 1; k--) begin
            y = y - 12'(k);
            run_frame(0, 0, (k == 1) ? 2'd2 : 2'd1, y, 0, "dbl_rise");
        end

        // Press while airborne at the apex.
`ifdef DOUBLE_JUMP_EN
        run_frame(0, 1, 1, 264, 0, "air_press");
        run_frame(0, 0, 1, 252, 0, "air_next");
`else
        run_frame(0, 1, 2, 264, 0, "air_press");
        run_frame(0, 0, 2, 265, 0, "air_next");
`endif

        // Reset asserted mid-jump takes effect without a clock edge.
        @(negedge clk) rst = 1'b0;
        #1 check("async_y", char_y, 400);
        check("async_st", state_o, 2);
        @(negedge clk) rst = 1'b1;
        run_frame(1, 0, 0, 400, 0, "rj_land");
        run_frame(1, 1, 1, 400, 0, "rj_jump");
        run_frame(1, 0, 1, 388, 0, "rj_rise");
        @(negedge clk) rst = 1'b0;
        #1 check("midjump_y", char_y, 400);
        check("midjump_st", state_o, 2);
        check("midjump_y_low", char_y_low, 5);
        @(negedge clk) rst = 1'b1;

        // Ceiling clamp with Y_START=5.
        run_frame(1, 0, 0, 5, 1, "low_land");
        run_frame(1, 1, 1, 5, 1, "low_jump");
        run_frame(0, 0, 2, 0, 1, "low_clamp");
        run_frame(0, 0, 2, 0, 1, "low_apex");
        run_frame(0, 0, 2, 1, 1, "low_fall");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
